// File: rtl/sum_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sum_adder_pkg
//  Description : Shared types and defaults for the sum-adder controller:
//                FSM state encoding, width defaults and watchdog limit.
//  Revision    : 1.0  initial release
// ============================================================================
package sum_adder_pkg;

    // Default width of N (inBus / Nreg on the datapath)
    localparam int N_WIDTH_DEFAULT   = 8;

    // Default width of the running sum and of the captured result.
    // Must be at least twice N_WIDTH so N*(N+1)/2 never truncates.
    localparam int SUM_WIDTH_DEFAULT = 16;

    // Number of non-terminating ACCUM cycles tolerated before a run is aborted
    localparam int WDOG_LIMIT        = 2 ** N_WIDTH_DEFAULT;

    // Controller state encoding
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_CAPTURE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

endpackage : sum_adder_pkg
`default_nettype wire

// File: rtl/sum_adder_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : sum_adder_controller_if
//  Description : Bundles the upstream start/inReady handshake, the datapath
//                control/status lines and the downstream valid/ready result
//                channel of the sum-adder controller.
//                master : controller side, slave : environment side.
//  Revision    : 1.0  initial release
// ============================================================================
interface sum_adder_controller_if #(
    parameter int SUM_WIDTH = 16
);

    // Upstream handshake
    logic                 start;
    logic                 inReady;

    // Datapath control
    logic                 NregEn;
    logic                 counterInit;
    logic                 counterEn;
    logic                 sumRegEn;
    logic                 dpRstN;

    // Datapath status
    logic                 nEqual;
    logic [SUM_WIDTH-1:0] dataIn;

    // Downstream result channel
    logic [SUM_WIDTH-1:0] outData;
    logic                 outValid;
    logic                 outReady;

    // Status
    logic                 busy;
    logic                 err;

    modport master (
        input  start,
        input  nEqual,
        input  dataIn,
        input  outReady,
        output inReady,
        output NregEn,
        output counterInit,
        output counterEn,
        output sumRegEn,
        output dpRstN,
        output outData,
        output outValid,
        output busy,
        output err
    );

    modport slave (
        output start,
        output nEqual,
        output dataIn,
        output outReady,
        input  inReady,
        input  NregEn,
        input  counterInit,
        input  counterEn,
        input  sumRegEn,
        input  dpRstN,
        input  outData,
        input  outValid,
        input  busy,
        input  err
    );

endinterface : sum_adder_controller_if
`default_nettype wire

// File: rtl/sum_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : sum_watchdog
//  Description : Counts ACCUM cycles that did not terminate the run and flags
//                a timeout once 2**N_WIDTH of them have elapsed. The counter
//                is one bit wider than N so the limit itself is representable.
//  Revision    : 1.0  initial release
// ============================================================================
import sum_adder_pkg::*;

module sum_watchdog #(
    parameter int N_WIDTH = N_WIDTH_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,      // synchronous, active-low
    input  wire logic clr,      // restart counting from zero
    input  wire logic en,       // one more non-terminating cycle
    output logic      timeout
);

    // Limit is 2**N_WIDTH, i.e. only the MSB of the counter set
    localparam logic [N_WIDTH:0] c_LIMIT = {1'b1, {N_WIDTH{1'b0}}};

    logic [N_WIDTH:0] r_count;

    assign timeout = (r_count == c_LIMIT);

    // Cycle counter: cleared by reset or a new run, saturates at the limit
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_count <= '0;
        end else if (en && !timeout) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : sum_watchdog
`default_nettype wire

// File: rtl/sum_adder_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sum_adder_controller
//  Description : Control FSM for the sum-of-0..N datapath. Accepts N on a
//                start/inReady handshake, sequences the datapath enables,
//                captures the final sum into its own result register and
//                offers it downstream on valid/ready. A watchdog aborts a run
//                whose nEqual never arrives and raises a sticky err flag.
//  Revision    : 1.0  initial release
// ============================================================================
import sum_adder_pkg::*;

module sum_adder_controller #(
    parameter int N_WIDTH   = N_WIDTH_DEFAULT,
    parameter int SUM_WIDTH = SUM_WIDTH_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst,      // synchronous, active-low
    sum_adder_controller_if.master bus
);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_next;

    logic [SUM_WIDTH-1:0] r_outData;
    logic                 r_outValid;
    logic                 r_err;

    // ------------------------------------------------------------------
    // Decoded control from the next-state logic
    // ------------------------------------------------------------------
    logic w_accept;       // start taken in IDLE; doubles as the datapath clear pulse
    logic w_inReady;
    logic w_nregEn;
    logic w_counterInit;
    logic w_counterEn;
    logic w_sumRegEn;
    logic w_capture;      // load result register from the datapath sum
    logic w_handshake;    // downstream consumed the result
    logic w_abort;        // watchdog expired without nEqual
    logic w_wdEn;         // count one more non-terminating ACCUM cycle
    logic w_timeout;

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    sum_watchdog #(
        .N_WIDTH (N_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_accept),
        .en      (w_wdEn),
        .timeout (w_timeout)
    );

    // State register; reset returns to IDLE from anywhere, discarding a run
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Mealy control decode; nEqual has priority over timeout
    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        w_inReady     = 1'b0;
        w_nregEn      = 1'b0;
        w_counterInit = 1'b0;
        w_counterEn   = 1'b0;
        w_sumRegEn    = 1'b0;
        w_capture     = 1'b0;
        w_handshake   = 1'b0;
        w_abort       = 1'b0;
        w_wdEn        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_inReady = 1'b1;
                if (bus.start) begin
                    w_accept      = 1'b1;
                    w_nregEn      = 1'b1;
                    w_counterInit = 1'b1;
                    w_next        = S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (bus.nEqual) begin
                    // Final add of N; the counter stays put
                    w_sumRegEn = 1'b1;
                    w_next     = S_CAPTURE;
                end else if (w_timeout) begin
                    // Give up: no enables, no result
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else begin
                    w_sumRegEn  = 1'b1;
                    w_counterEn = 1'b1;
                    w_wdEn      = 1'b1;
                end
            end

            S_CAPTURE: begin
                w_capture = 1'b1;
                w_next    = S_OUTPUT;
            end

            S_OUTPUT: begin
                if (r_outValid && bus.outReady) begin
                    w_handshake = 1'b1;
                    w_next      = S_IDLE;
                end
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Result register and its valid flag; data holds until consumed
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
        end else if (w_capture) begin
            r_outData  <= bus.dataIn;
            r_outValid <= 1'b1;
        end else if (w_handshake) begin
            r_outValid <= 1'b0;
        end
    end

    // Sticky watchdog error; a newly accepted run clears it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.inReady     = w_inReady;
    assign bus.NregEn      = w_nregEn;
    assign bus.counterInit = w_counterInit;
    assign bus.counterEn   = w_counterEn;
    assign bus.sumRegEn    = w_sumRegEn;
    // Datapath is cleared both by system reset and at each accept
    assign bus.dpRstN      = rst & ~w_accept;
    assign bus.outData     = r_outData;
    assign bus.outValid    = r_outValid;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.err         = r_err;

endmodule : sum_adder_controller
`default_nettype wire

// File: tb/tb_sum_adder_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_adder_controller
//  Description : Bench for sum_adder_controller. A behavioural model of the
//                sum-adder datapath closes the loop; expected results and
//                latencies are hand-computed constants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sum_adder_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] inBus = '0;
    logic       force_neq = 1'b0;

    // Datapath model state
    logic [7:0]  dp_n   = '0;
    logic [7:0]  dp_cnt = '0;
    logic [15:0] dp_sum = '0;

    int checks = 0;
    int errors = 0;

    sum_adder_controller_if #(.SUM_WIDTH(16)) bus ();

    sum_adder_controller #(
        .N_WIDTH   (8),
        .SUM_WIDTH (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Datapath model
    always @(posedge clk) begin
        if (bus.NregEn) dp_n <= inBus;
        if (bus.counterInit) dp_cnt <= '0;
        else if (bus.counterEn) dp_cnt <= dp_cnt + 8'd1;
        if (!bus.dpRstN) dp_sum <= '0;
        else if (bus.sumRegEn) dp_sum <= dp_sum + {8'd0, dp_cnt};
    end

    assign bus.nEqual = (dp_cnt == dp_n) && !force_neq;
    assign bus.dataIn = dp_sum;

    typedef struct {
        logic [7:0]  n;
        logic [15:0] exp_sum;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present start with N for one cycle; returns in cycle 1 of the run
    task automatic do_accept(input logic [7:0] n);
        bus.start = 1'b1;
        inBus     = n;
        #1;
        chk("acc_inReady",     32'(bus.inReady),     32'd1);
        chk("acc_NregEn",      32'(bus.NregEn),      32'd1);
        chk("acc_counterInit", 32'(bus.counterInit), 32'd1);
        chk("acc_dpRstN",      32'(bus.dpRstN),      32'd0);
        tick();
        bus.start = 1'b0;
    endtask

    // Advance until outValid; cyc is the current cycle index on entry/exit
    task automatic wait_valid(inout int cyc);
        while (!bus.outValid && cyc < 600) begin
            tick();
            cyc++;
        end
    endtask

    task automatic consume();
        bus.outReady = 1'b1;
        tick();
        bus.outReady = 1'b0;
        chk("cons_outValid", 32'(bus.outValid), 32'd0);
        chk("cons_inReady",  32'(bus.inReady),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  saw_valid;

        vecs[0] = '{8'd10, 16'd55,  13};
        vecs[1] = '{8'd0,  16'd0,   3};
        vecs[2] = '{8'd1,  16'd1,   4};
        vecs[3] = '{8'd5,  16'd15,  8};
        vecs[4] = '{8'd20, 16'd210, 23};

        bus.start    = 1'b0;
        bus.outReady = 1'b0;

        // Reset state
        rst = 1'b0;
        tick(); tick();
        chk("rst_outValid", 32'(bus.outValid), 32'd0);
        chk("rst_outData",  32'(bus.outData),  32'd0);
        chk("rst_err",      32'(bus.err),      32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_inReady",  32'(bus.inReady),  32'd1);
        chk("rst_dpRstN",   32'(bus.dpRstN),   32'd0);
        rst = 1'b1;
        tick();
        chk("run_dpRstN",   32'(bus.dpRstN),   32'd1);

        // Table-driven transactions
        for (int i = 0; i < 5; i++) begin
            do_accept(vecs[i].n);
            cyc = 1;
            chk("vec_busy",    32'(bus.busy),    32'd1);
            chk("vec_inReady", 32'(bus.inReady), 32'd0);
            wait_valid(cyc);
            chk("vec_latency", 32'(cyc), 32'(vecs[i].exp_cyc));
            chk("vec_sum",     32'(bus.outData), 32'(vecs[i].exp_sum));
            consume();
        end

        // N=255, downstream stalls; start pulsed during OUTPUT is ignored
        do_accept(8'd255);
        cyc = 1;
        wait_valid(cyc);
        chk("max_latency", 32'(cyc), 32'd258);
        for (int i = 0; i < 20; i++) begin
            bus.start = (i == 5);
            inBus     = 8'd7;
            #1;
            if (i == 5) chk("out_start_NregEn", 32'(bus.NregEn), 32'd0);
            chk("stall_outData",  32'(bus.outData),  32'd32640);
            chk("stall_outValid", 32'(bus.outValid), 32'd1);
            chk("stall_inReady",  32'(bus.inReady),  32'd0);
            tick();
            bus.start = 1'b0;
        end
        chk("stall_final_data", 32'(bus.outData), 32'd32640);
        consume();
        chk("stall_idle_busy", 32'(bus.busy), 32'd0);

        // Watchdog: nEqual never arrives
        force_neq = 1'b1;
        do_accept(8'd3);
        cyc = 1;
        saw_valid = 1'b0;
        while (bus.busy && cyc < 600) begin
            if (bus.outValid) saw_valid = 1'b1;
            tick();
            cyc++;
        end
        chk("wd_idle_cycle", 32'(cyc),       32'd258);
        chk("wd_err",        32'(bus.err),   32'd1);
        chk("wd_no_valid",   32'(saw_valid), 32'd0);
        chk("wd_outValid",   32'(bus.outValid), 32'd0);
        tick();
        chk("wd_err_sticky", 32'(bus.err),   32'd1);
        force_neq = 1'b0;
        do_accept(8'd2);
        cyc = 1;
        chk("wd_err_clear", 32'(bus.err), 32'd0);
        wait_valid(cyc);
        chk("wd_next_sum", 32'(bus.outData), 32'd3);
        consume();

        // Reset in the middle of ACCUM
        do_accept(8'd100);
        tick(); tick(); tick(); tick();
        chk("mid_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        tick();
        chk("mid_busy",      32'(bus.busy),      32'd0);
        chk("mid_outValid",  32'(bus.outValid),  32'd0);
        chk("mid_outData",   32'(bus.outData),   32'd0);
        chk("mid_err",       32'(bus.err),       32'd0);
        chk("mid_dpRstN",    32'(bus.dpRstN),    32'd0);
        chk("mid_counterEn", 32'(bus.counterEn), 32'd0);
        chk("mid_sumRegEn",  32'(bus.sumRegEn),  32'd0);
        chk("mid_inReady",   32'(bus.inReady),   32'd1);
        rst = 1'b1;
        tick();

        // N=4 with a stray start during ACCUM
        do_accept(8'd4);
        cyc = 1;
        tick();
        cyc++;
        bus.start = 1'b1;
        inBus     = 8'd99;
        #1;
        chk("accum_start_NregEn",  32'(bus.NregEn),  32'd0);
        chk("accum_start_inReady", 32'(bus.inReady), 32'd0);
        tick();
        cyc++;
        bus.start = 1'b0;
        wait_valid(cyc);
        chk("after_rst_latency", 32'(cyc),         32'd7);
        chk("after_rst_sum",     32'(bus.outData), 32'd10);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sum_adder_controller
`default_nettype wire
